// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry writeback FIFO between the ALU and the register-file write port.
// Latency: an entry enqueued on edge k presents WbValid from edge k, so writeback can happen on edge k+1.
// Backpressure: InReady drops only when both slots are held. It never looks at WbReady.
// Flags {N,Z,V,C} commit in FIFO order, on the dequeue of an entry whose upd bit is set.
// Optional feature macro: ALU_FWD_EN adds FwdValid/FwdReg/FwdData, the newest held entry, for operand forwarding.
// Ports: Clock/Reset (sync, active-high); InValid/InReady + Result/Carry/Overflow/DestReg/UpdateFlags in;
//        WbValid/WbReady + WbData/WbReg out; Flags, Count status.
module alu_result_stage #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   Result,
  input  logic               Carry,
  input  logic               Overflow,
  input  logic [REGBITS-1:0] DestReg,
  input  logic               UpdateFlags,
  output logic               WbValid,
  input  logic               WbReady,
  output logic [WIDTH-1:0]   WbData,
  output logic [REGBITS-1:0] WbReg,
  output logic [3:0]         Flags,
`ifdef ALU_FWD_EN
  output logic               FwdValid,
  output logic [REGBITS-1:0] FwdReg,
  output logic [WIDTH-1:0]   FwdData,
`endif
  output logic [1:0]         Count
);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [REGBITS-1:0] rg;
    logic               n;
    logic               z;
    logic               v;
    logic               c;
    logic               upd;
  } slot_t;

  // The state encoding is the entry count itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  slot_t  slots [2];
  logic   head;
  logic   tail;
  logic   enq;
  logic   deq;
  slot_t  new_entry;

  assign Count   = state;
  assign InReady = (state != FULL);
  assign WbValid = (state != EMPTY);
  assign enq     = InValid && InReady;
  assign deq     = WbValid && WbReady;

  // Flags are captured at enqueue and only applied when the entry commits.
  always_comb begin
    new_entry      = '0;
    new_entry.data = Result;
    new_entry.rg   = DestReg;
    new_entry.n    = Result[WIDTH-1];
    new_entry.z    = (Result == '0);
    new_entry.v    = Overflow;
    new_entry.c    = Carry;
    new_entry.upd  = UpdateFlags;
  end

  // Slot contents are cleared on reset, but the outputs are still gated on
  // EMPTY so that stale data from a drained slot never leaks out.
  assign WbData = WbValid ? slots[head].data : '0;
  assign WbReg  = WbValid ? slots[head].rg   : '0;

`ifdef ALU_FWD_EN
  // The newest entry sits one slot behind tail. With only two slots, that is ~tail.
  assign FwdValid = (state != EMPTY);
  assign FwdReg   = FwdValid ? slots[~tail].rg   : '0;
  assign FwdData  = FwdValid ? slots[~tail].data : '0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
      Flags <= 4'b0000;
      for (int i = 0; i < 2; i++) slots[i] <= '0;
    end else begin
      if (enq) begin
        slots[tail] <= new_entry;
        tail        <= ~tail;
      end
      if (deq) begin
        head <= ~head;
        if (slots[head].upd)
          Flags <= {slots[head].n, slots[head].z, slots[head].v, slots[head].c};
      end
      case (state)
        EMPTY: if (enq) state <= ONE;
        ONE: begin
          if (enq && !deq)      state <= FULL;
          else if (deq && !enq) state <= EMPTY;
        end
        FULL:    if (deq) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage. It checks reset, single op, backpressure, simultaneous
// enqueue/dequeue, flag commit ordering, reset while FULL, and forwarding when ALU_FWD_EN is set.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_result_stage;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               InValid;
  logic               InReady;
  logic [WIDTH-1:0]   Result;
  logic               Carry;
  logic               Overflow;
  logic [REGBITS-1:0] DestReg;
  logic               UpdateFlags;
  logic               WbValid;
  logic               WbReady;
  logic [WIDTH-1:0]   WbData;
  logic [REGBITS-1:0] WbReg;
  logic [3:0]         Flags;
  logic [1:0]         Count;
`ifdef ALU_FWD_EN
  logic               FwdValid;
  logic [REGBITS-1:0] FwdReg;
  logic [WIDTH-1:0]   FwdData;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_result_stage #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .Result      (Result),
    .Carry       (Carry),
    .Overflow    (Overflow),
    .DestReg     (DestReg),
    .UpdateFlags (UpdateFlags),
    .WbValid     (WbValid),
    .WbReady     (WbReady),
    .WbData      (WbData),
    .WbReg       (WbReg),
    .Flags       (Flags),
`ifdef ALU_FWD_EN
    .FwdValid    (FwdValid),
    .FwdReg      (FwdReg),
    .FwdData     (FwdData),
`endif
    .Count       (Count)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic offer(input logic [15:0] res, input logic [3:0] rg, input logic c, input logic v,
                       input logic upd);
    InValid     = 1'b1;
    Result      = res;
    DestReg     = rg;
    Carry       = c;
    Overflow    = v;
    UpdateFlags = upd;
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; Result = '0; Carry = 1'b0; Overflow = 1'b0;
    DestReg = '0; UpdateFlags = 1'b0; WbReady = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    check_val("rst_count", Count, 0);
    check_val("rst_inready", InReady, 1);
    check_val("rst_wbvalid", WbValid, 0);
    check_val("rst_wbdata", WbData, 0);
    check_val("rst_wbreg", WbReg, 0);
    check_val("rst_flags", Flags, 4'b0000);

    // Single op: zero result with carry, which sets Z and C.
    offer(16'h0000, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    InValid = 1'b0;
    check_val("single_wbvalid", WbValid, 1);
    check_val("single_wbdata", WbData, 16'h0000);
    check_val("single_wbreg", WbReg, 3);
    check_val("single_flags_pre", Flags, 4'b0000);
    WbReady = 1'b1;
    tick();
    WbReady = 1'b0;
    check_val("single_flags", Flags, 4'b0101);
    check_val("single_count", Count, 0);

    // Backpressure: three ops offered, and only two fit.
    offer(16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    offer(16'h0002, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    offer(16'h0003, 4'd3, 1'b0, 1'b0, 1'b0);
    check_val("bp_count_full", Count, 2);
    check_val("bp_inready", InReady, 0);
    tick();
    check_val("bp_stall_count", Count, 2);
    check_val("bp_head1", WbData, 16'h0001);
    WbReady = 1'b1;
    tick();
    check_val("bp_head2", WbData, 16'h0002);
    check_val("bp_reg2", WbReg, 2);
    check_val("bp_count1", Count, 1);
    tick();
    InValid = 1'b0;
    check_val("bp_head3", WbData, 16'h0003);
    check_val("bp_count1b", Count, 1);
    tick();
    check_val("bp_drained", WbValid, 0);
    check_val("bp_flags_hold", Flags, 4'b0101);

    // WbReady while EMPTY has no effect.
    tick();
    check_val("empty_rdy_count", Count, 0);
    check_val("empty_rdy_flags", Flags, 4'b0101);
    WbReady = 1'b0;

    // Simultaneous enqueue and dequeue at Count=1.
    offer(16'h0010, 4'd4, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("sim_count_pre", Count, 1);
    offer(16'h0020, 4'd5, 1'b0, 1'b0, 1'b0);
    WbReady = 1'b1;
    tick();
    InValid = 1'b0;
    WbReady = 1'b0;
    check_val("sim_count", Count, 1);
    check_val("sim_wbdata", WbData, 16'h0020);
    check_val("sim_wbreg", WbReg, 5);
    WbReady = 1'b1;
    tick();
    WbReady = 1'b0;
    check_val("sim_empty", Count, 0);

    // Flag ordering: only the upd entry commits flags.
    offer(16'h8000, 4'd6, 1'b0, 1'b0, 1'b1);
    tick();
    offer(16'h0005, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    InValid = 1'b0;
    check_val("ord_count", Count, 2);
    check_val("ord_flags_enq", Flags, 4'b0101);
    WbReady = 1'b1;
    tick();
    check_val("ord_flags1", Flags, 4'b1000);
    check_val("ord_wbdata2", WbData, 16'h0005);
    tick();
    WbReady = 1'b0;
    check_val("ord_flags2", Flags, 4'b1000);
    check_val("ord_count0", Count, 0);

    // Fill to FULL. The head entry would commit V if it were written.
    offer(16'h00AA, 4'd2, 1'b0, 1'b1, 1'b1);
    tick();
`ifdef ALU_FWD_EN
    check_val("fwd_valid", FwdValid, 1);
    check_val("fwd_data1", FwdData, 16'h00AA);
`endif
    offer(16'h00BB, 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    InValid = 1'b0;
    check_val("full_count", Count, 2);
`ifdef ALU_FWD_EN
    check_val("fwd_reg", FwdReg, 2);
    check_val("fwd_data2", FwdData, 16'h00BB);
`endif

    // Reset while FULL with WbReady high: nothing commits.
    Reset = 1'b1;
    WbReady = 1'b1;
    tick();
    Reset = 1'b0;
    WbReady = 1'b0;
    check_val("rstfull_flags", Flags, 4'b0000);
    check_val("rstfull_wbvalid", WbValid, 0);
    check_val("rstfull_inready", InReady, 1);
    check_val("rstfull_count", Count, 0);
    check_val("rstfull_wbdata", WbData, 0);
`ifdef ALU_FWD_EN
    check_val("rstfull_fwdvalid", FwdValid, 0);
    check_val("rstfull_fwddata", FwdData, 0);
`endif
    tick();
    check_val("rstfull_count_next", Count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
